// File: rtl/ss_rvc_pkg.sv
// ----------------------------------------------------------------------------
// ss_rvc_pkg
// Shared types and constants for the ss_rvc core slice.
//   t_xlen        : native data/address word of the core
//   ARB_STARVE_W  : width of the memory-arbiter starvation counter
//   t_arb_rsp_st  : owner of the read that is in flight in the shared memory
// No ports (package).
// ----------------------------------------------------------------------------
package ss_rvc_pkg;

    localparam int unsigned XLEN_DFLT = 32;
    typedef logic [XLEN_DFLT-1:0] t_xlen;

    localparam int unsigned ARB_STARVE_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_RSP = 2'd1,
        DM_RSP = 2'd2
    } t_arb_rsp_st;

endpackage

// File: rtl/ss_rvc_arb_starve_cnt.sv
// ----------------------------------------------------------------------------
// ss_rvc_arb_starve_cnt
// Saturating count of consecutive cycles in which the fetch requester asked
// for the memory and was refused.
// Ports:
//   i_clk     : clock, rising edge
//   i_rst_n   : asynchronous active-low reset
//   i_req     : fetch requester is asking this cycle
//   i_gnt     : fetch requester was granted this cycle
//   i_max     : saturation value (1..15)
//   o_at_max  : count has reached i_max, fetch must win the next conflict
// ----------------------------------------------------------------------------
module ss_rvc_arb_starve_cnt
    import ss_rvc_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req,
    input  logic                    i_gnt,
    input  logic [ARB_STARVE_W-1:0] i_max,
    output logic                    o_at_max
);

    logic [ARB_STARVE_W-1:0] r_cnt;

    // Count up on every refused request. Any grant, or a cycle where the
    // fetch side is not asking, means it is no longer being starved, so the
    // count starts over. Holding at i_max keeps o_at_max asserted until the
    // fetch side actually gets through.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_req || i_gnt) begin
            r_cnt <= '0;
        end else if (r_cnt != i_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_at_max = (r_cnt == i_max);

endmodule

// File: rtl/ss_rvc_mem_arb.sv
// ----------------------------------------------------------------------------
// ss_rvc_mem_arb
// Shares one single-port unified memory between the instruction-fetch stage
// (Q100H) and the data-memory stage (Q103H). One requester is granted per
// cycle; the 1-cycle read data is routed back to whoever issued the read.
// Optional macro: SS_RVC_MEM_ARB_STATS_EN adds ConflictCnt / IfStarveCnt.
// Ports:
//   QClk, RstQnnnH          : clock / async active-low reset
//   IfReqQ100H, IfAddrQ100H : fetch request and address
//   IfGntQ100H              : fetch granted this cycle
//   IfRdDataQ101H/RspVld    : fetch response, one cycle after grant
//   DmRdEn/WrEn/Addr/WrData : data-memory request (Q103H)
//   DmGntQ103H              : data request granted this cycle
//   DmRdDataQ104H/RspVld    : load response, one cycle after grant
//   MemAddr/WrData/RdEn/WrEn: shared memory port
//   MemRdData               : memory read data, 1 cycle after MemRdEn
//   ConflictCnt, IfStarveCnt: statistics (macro only)
// ----------------------------------------------------------------------------
module ss_rvc_mem_arb
    import ss_rvc_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned STARVE_MAX = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic            QClk,
    input  logic            RstQnnnH,
    input  logic            IfReqQ100H,
    input  logic [XLEN-1:0] IfAddrQ100H,
    output logic            IfGntQ100H,
    output logic [XLEN-1:0] IfRdDataQ101H,
    output logic            IfRspVldQ101H,
    input  logic            DmRdEnQ103H,
    input  logic            DmWrEnQ103H,
    input  logic [XLEN-1:0] DmAddrQ103H,
    input  logic [XLEN-1:0] DmWrDataQ103H,
    output logic            DmGntQ103H,
    output logic [XLEN-1:0] DmRdDataQ104H,
    output logic            DmRspVldQ104H,
    output logic [XLEN-1:0] MemAddr,
    output logic [XLEN-1:0] MemWrData,
    output logic            MemRdEn,
    output logic            MemWrEn,
    input  logic [XLEN-1:0] MemRdData
`ifdef SS_RVC_MEM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] ConflictCnt,
    output logic [CNT_W-1:0] IfStarveCnt
`endif
);

    localparam logic [ARB_STARVE_W-1:0] STARVE_MAX_V = ARB_STARVE_W'(STARVE_MAX);

    t_arb_rsp_st     r_state;
    t_arb_rsp_st     w_nextState;
    logic            r_active;
    logic [XLEN-1:0] r_lastAddr;
    logic [XLEN-1:0] r_lastWrData;
    logic            w_dmReq;
    logic            w_dmRd;
    logic            w_ifReqAct;
    logic            w_dmReqAct;
    logic            w_atMax;
    logic            w_ifGnt;
    logic            w_dmGnt;

    // r_active is cleared by reset and set on the first clock edge after
    // release. Gating every grant with it makes the grants and memory
    // enables drop the instant reset asserts, and keeps arbitration off
    // until the first edge after reset is released.
    always_ff @(posedge QClk or negedge RstQnnnH) begin
        if (!RstQnnnH) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    // A simultaneous read and write from the data stage is treated as a
    // write only; the read is never issued.
    assign w_dmReq    = DmRdEnQ103H | DmWrEnQ103H;
    assign w_dmRd     = DmRdEnQ103H & ~DmWrEnQ103H;
    assign w_ifReqAct = r_active & IfReqQ100H;
    assign w_dmReqAct = r_active & w_dmReq;

    // Data stage holds the older instruction, so it normally wins a
    // conflict; once fetch has been refused STARVE_MAX times in a row it
    // goes first. The two grants are exclusive by construction.
    assign w_ifGnt = w_ifReqAct & (~w_dmReqAct | w_atMax);
    assign w_dmGnt = w_dmReqAct & ~w_ifGnt;

    ss_rvc_arb_starve_cnt u_starve_cnt (
        .i_clk    (QClk),
        .i_rst_n  (RstQnnnH),
        .i_req    (w_ifReqAct),
        .i_gnt    (w_ifGnt),
        .i_max    (STARVE_MAX_V),
        .o_at_max (w_atMax)
    );

    assign IfGntQ100H = w_ifGnt;
    assign DmGntQ103H = w_dmGnt;

    // Remember what was last driven on the shared address/data bus so the
    // bus stays quiet (no toggling) on cycles with no grant. Fetch carries
    // no write data, so the write-data bus only follows the data stage.
    always_ff @(posedge QClk or negedge RstQnnnH) begin
        if (!RstQnnnH) begin
            r_lastAddr   <= '0;
            r_lastWrData <= '0;
        end else if (w_ifGnt) begin
            r_lastAddr   <= IfAddrQ100H;
        end else if (w_dmGnt) begin
            r_lastAddr   <= DmAddrQ103H;
            r_lastWrData <= DmWrDataQ103H;
        end
    end

    // Shared memory port: steer the granted requester onto the bus.
    always_comb begin
        MemAddr   = r_lastAddr;
        MemWrData = r_lastWrData;
        MemRdEn   = 1'b0;
        MemWrEn   = 1'b0;
        if (w_ifGnt) begin
            MemAddr = IfAddrQ100H;
            MemRdEn = 1'b1;
        end else if (w_dmGnt) begin
            MemAddr   = DmAddrQ103H;
            MemWrData = DmWrDataQ103H;
            MemRdEn   = w_dmRd;
            MemWrEn   = DmWrEnQ103H;
        end
    end

    // Response owner register: records who issued the read that the
    // memory is answering this cycle.
    always_ff @(posedge QClk or negedge RstQnnnH) begin
        if (!RstQnnnH) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next owner follows this cycle's grant directly, so reads may issue
    // back to back. The read data is handed only to the owner; the other
    // data bus is held at zero.
    always_comb begin
        w_nextState   = IDLE;
        IfRspVldQ101H = 1'b0;
        IfRdDataQ101H = '0;
        DmRspVldQ104H = 1'b0;
        DmRdDataQ104H = '0;
        if (w_ifGnt) begin
            w_nextState = IF_RSP;
        end else if (w_dmGnt && w_dmRd) begin
            w_nextState = DM_RSP;
        end
        case (r_state)
            IF_RSP: begin
                IfRspVldQ101H = 1'b1;
                IfRdDataQ101H = MemRdData;
            end
            DM_RSP: begin
                DmRspVldQ104H = 1'b1;
                DmRdDataQ104H = MemRdData;
            end
            default: begin
            end
        endcase
    end

`ifdef SS_RVC_MEM_ARB_STATS_EN
    logic [CNT_W-1:0] r_conflictCnt;
    logic [CNT_W-1:0] r_ifStarveCnt;

    // Statistics: a conflict is any active cycle with both stages asking;
    // fetch winning while the data stage is also asking can only happen
    // through the starvation override. Both counters wrap naturally.
    always_ff @(posedge QClk or negedge RstQnnnH) begin
        if (!RstQnnnH) begin
            r_conflictCnt <= '0;
            r_ifStarveCnt <= '0;
        end else begin
            if (w_ifReqAct && w_dmReqAct) begin
                r_conflictCnt <= r_conflictCnt + 1'b1;
            end
            if (w_ifGnt && w_dmReqAct) begin
                r_ifStarveCnt <= r_ifStarveCnt + 1'b1;
            end
        end
    end

    assign ConflictCnt = r_conflictCnt;
    assign IfStarveCnt = r_ifStarveCnt;
`else
    logic [CNT_W-1:0] w_unusedStats;
    assign w_unusedStats = '0;
`endif

endmodule

// File: doc/ss_rvc_mem_arb.md
Name: ss_rvc_mem_arb

Overview:
- Arbiter that shares one single-port unified memory between the core's instruction-fetch requester (Q100H) and data-memory requester (Q103H).
- Grants one requester per cycle and drives the shared memory port.
- Routes the 1-cycle-latency read data back to the requester that was granted.
- Gives the core per-requester grants, so the core freezes whichever stage lost arbitration. Sits between the ss_rvc core and the memory macro.

Parameters:
- XLEN, 32, data/address width.
- STARVE_MAX, 3, consecutive IF denials tolerated before IF is forced ahead of DM; legal range 1..15.
- CNT_W, 16, width of statistics counters (optional feature only).

Ports:
- QClk  in  1  clock, all flops on rising edge.
- RstQnnnH  in  1  asynchronous active-low reset.
- IfReqQ100H  in  1  fetch request (read only).
- IfAddrQ100H  in  XLEN  fetch address.
- IfGntQ100H  out  1  fetch granted this cycle.
- IfRdDataQ101H  out  XLEN  fetch data, valid when IfRspVldQ101H.
- IfRspVldQ101H  out  1  fetch response valid.
- DmRdEnQ103H  in  1  data read request.
- DmWrEnQ103H  in  1  data write request.
- DmAddrQ103H  in  XLEN  data address.
- DmWrDataQ103H  in  XLEN  write data.
- DmGntQ103H  out  1  data request granted this cycle.
- DmRdDataQ104H  out  XLEN  load data, valid when DmRspVldQ104H.
- DmRspVldQ104H  out  1  load response valid.
- MemAddr  out  XLEN  shared memory address.
- MemWrData  out  XLEN  shared memory write data.
- MemRdEn  out  1  shared memory read enable.
- MemWrEn  out  1  shared memory write enable.
- MemRdData  in  XLEN  memory read data, 1 cycle after MemRdEn.

Behaviour:
- Reset (RstQnnnH=0, async): state=IDLE, starvation counter=0. All outputs 0, including both grants, both response valids, and all Mem* outputs. Recovery is synchronous to the next QClk edge.
- Request definitions: DM request = DmRdEnQ103H | DmWrEnQ103H. If both DmRdEnQ103H and DmWrEnQ103H are 1, the write wins and no read is issued.
- Grant is combinational from the current requests and the registered starvation counter:
  - Only one requester active: that requester is granted.
  - Both active: DM wins (it is the older instruction), unless starvation count == STARVE_MAX, in which case IF wins.
  - At most one grant per cycle.
- Mem* outputs mux the granted requester's address, data and enables. With no grant, MemRdEn=MemWrEn=0; MemAddr and MemWrData hold their last value.
- Starvation counter (4 bits):
  - Increments when IF requests and is denied.
  - Clears when IF is granted or IF does not request.
  - Saturates at STARVE_MAX.
- Response FSM, registered owner of the in-flight read:
  - IDLE: no read issued last cycle.
  - IF_RSP: IF read issued last cycle.
  - DM_RSP: DM read issued last cycle.
  - Next state = IF_RSP if IF granted; DM_RSP if a DM read is granted; IDLE otherwise (a DM write or no grant goes to IDLE). Any state can move to any state every cycle, so reads can issue back-to-back.
- Response outputs:
  - IF_RSP: IfRspVldQ101H=1 and IfRdDataQ101H=MemRdData.
  - DM_RSP: DmRspVldQ104H=1 and DmRdDataQ104H=MemRdData.
  - Response data outputs are 0 when their valid is 0.
- Latency: grant to response is exactly 1 cycle; the arbiter adds no bubble.
- Requester obligations: a denied requester holds its request and payload stable until granted, because the core freezes on a denied grant. The arbiter does not store requests.
- Reset asserted mid-read: the response is dropped (valid forced 0) and the state returns to IDLE.

Optional Feature:
- Macro SS_RVC_MEM_ARB_STATS_EN.
- Defined: adds outputs ConflictCnt[CNT_W] and IfStarveCnt[CNT_W]. Both reset to 0 and wrap at 2^CNT_W.
  - ConflictCnt increments each cycle both requesters are active.
  - IfStarveCnt increments each cycle IF is granted because of starvation.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- ss_rvc_pkg gets typedef t_arb_rsp_st (enum IDLE, IF_RSP, DM_RSP).
- ss_rvc_pkg also gets the constant ARB_STARVE_W=4. Reuse the existing t_xlen.
- One natural sub-module: ss_rvc_arb_starve_cnt, the saturating starvation counter. Its inputs are req, gnt and max; its output is at_max.
- Everything else stays flat in ss_rvc_mem_arb.

Test Plan:
- IF-only stream, addresses 0x0, 0x4, 0x8 on consecutive cycles -> IfGntQ100H=1 every cycle; IfRspVldQ101H=1 one cycle later with the matching MemRdData; MemWrEn stays 0.
- DM write 0xDEADBEEF to 0x100 alone -> MemWrEn=1, MemAddr=0x100, DmGntQ103H=1, next state IDLE, no response valid. Then a DM read of 0x100 -> DmRspVldQ104H=1 with 0xDEADBEEF.
- IF and DM both request continuously, STARVE_MAX=3 -> grants DM, DM, DM, IF, repeating; counter clears after the IF grant.
- Back-to-back DM read then IF read -> DmRspVldQ104H in cycle N+1 and IfRspVldQ101H in cycle N+2; never both valid in the same cycle.
- Reset asserted during an IF_RSP cycle -> IfRspVldQ101H, IfGntQ100H, DmGntQ103H, MemRdEn and MemWrEn drop to 0 immediately (async). First grant resumes on the first edge after release.
- With SS_RVC_MEM_ARB_STATS_EN and 10 conflict cycles at STARVE_MAX=3 -> ConflictCnt=10 and IfStarveCnt=2 (IF forced ahead on the 4th and 8th conflict cycles).
